// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state encoding for the SPI register slave.
package spi_reg_pkg;

    localparam int RW_BIT      = 7;
    localparam int ADDR_BYTE_W = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        ADDR  = S_ADDR,
        WDATA = S_WDATA,
        RDATA = S_RDATA,
        NEXT  = S_NEXT
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for a bundle of asynchronous inputs, with rise/fall
// detection on one dedicated line (the serial clock).
module spi_sync_edge
    import spi_reg_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         edge_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         rise_o,
    output logic         fall_o
);

    // Bit W carries the edge-detected line; the lower bits are plain data.
    logic [W:0] sync_q [SYNC_STAGES];
    logic       prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {edge_i, data_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1][W];
        end
    end

    assign data_o = sync_q[SYNC_STAGES-1][W-1:0];
    assign rise_o = sync_q[SYNC_STAGES-1][W] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1][W] & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// Oversampled SPI register slave: address byte, then a write word or a readback word.
// Define SPI_BURST_EN to enable address auto-increment bursts while CS stays high.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int NREGS  = 8
) (
    input  logic                    FX2_CLK,
    input  logic                    RST,
    input  logic                    SCK,
    input  logic                    SI,
    input  logic                    CS,
    output logic                    SO,
    output logic                    SO_OE,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    wr_stb,
    input  logic [NREGS*DATA_W-1:0] rd_regs,
    output logic                    busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] ADDR_DONE = CNT_W'(ADDR_BYTE_W);
    localparam logic [CNT_W-1:0] WORD_DONE = CNT_W'(DATA_W);

    logic [1:0] sync_data;
    logic       sck_rise, sck_fall;

    spi_sync_edge #(.W(2)) u_sync (
        .clk_i  (FX2_CLK),
        .rst_i  (RST),
        .edge_i (SCK),
        .data_i ({CS, SI}),
        .data_o (sync_data),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // CS is delayed past the point where an SCK event is fully processed, so a
    // final rise arriving together with the CS drop still completes its word.
    logic       rise_q, fall_q, si_q;
    logic [2:0] cs_pipe_q;
    logic       cs_live;

    always_ff @(posedge FX2_CLK or posedge RST) begin
        if (RST) begin
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            si_q      <= 1'b0;
            cs_pipe_q <= '0;
        end else begin
            rise_q    <= sck_rise;
            fall_q    <= sck_fall;
            si_q      <= sync_data[0];
            cs_pipe_q <= {cs_pipe_q[1:0], sync_data[1]};
        end
    end

    assign cs_live = cs_pipe_q[2];

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] sh_q, sh_d, shift_in;
    logic [ADDR_W-1:0] addr_q, addr_d, load_addr;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, rd_word;
    logic              wr_stb_q, wr_stb_d;
    logic              so_q, so_d, so_oe_q, so_oe_d;

    // Readback mux: decoded address during ADDR, next burst address otherwise.
    always_comb begin
        load_addr = (state_q == ADDR) ? sh_q[ADDR_W-1:0] : addr_q + ADDR_W'(1);
        rd_word   = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (int'(load_addr) == k) rd_word = rd_regs[k*DATA_W +: DATA_W];
        end
    end

    assign cnt_inc  = (cnt_q == WORD_DONE) ? cnt_q : cnt_q + CNT_W'(1);
    assign shift_in = {sh_q[DATA_W-2:0], si_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        so_d      = so_q;
        so_oe_d   = so_oe_q;
        if (state_q != IDLE && !cs_live) begin
            state_d = IDLE;
            cnt_d   = '0;
            so_d    = 1'b0;
            so_oe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_live) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                        sh_d    = '0;
                    end
                end
                ADDR: begin
                    if (cnt_q == ADDR_DONE) begin
                        addr_d = sh_q[ADDR_W-1:0];
                        cnt_d  = '0;
                        if (sh_q[RW_BIT]) begin
                            sh_d    = rd_word;
                            so_d    = rd_word[DATA_W-1];
                            so_oe_d = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = WDATA;
                        end
                    end else if (rise_q) begin
                        sh_d  = shift_in;
                        cnt_d = cnt_inc;
                    end
                end
                WDATA: begin
                    if (cnt_q == WORD_DONE) begin
                        wr_addr_d = addr_q;
                        wr_data_d = sh_q;
                        wr_stb_d  = 1'b1;
`ifdef SPI_BURST_EN
                        addr_d = load_addr;
                        cnt_d  = '0;
`else
                        state_d = NEXT;
`endif
                    end else if (rise_q) begin
                        sh_d  = shift_in;
                        cnt_d = cnt_inc;
                    end
                end
                RDATA: begin
                    so_d = sh_q[DATA_W-1];
                    if (cnt_q == WORD_DONE) begin
`ifdef SPI_BURST_EN
                        // Burst re-entry is taken directly here so the reload lands on the same cycle as a strobe would.
                        addr_d = load_addr;
                        sh_d   = rd_word;
                        so_d   = rd_word[DATA_W-1];
                        cnt_d  = '0;
`else
                        state_d = NEXT;
                        so_d    = 1'b0;
                        so_oe_d = 1'b0;
`endif
                    end else begin
                        if (rise_q) cnt_d = cnt_inc;
                        // The MSB is already on SO; only falls after a data rise advance the word.
                        if (fall_q && cnt_q != '0) sh_d = {sh_q[DATA_W-2:0], 1'b0};
                    end
                end
                NEXT:    state_d = NEXT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge FX2_CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
            so_q      <= 1'b0;
            so_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            so_q      <= so_d;
            so_oe_q   <= so_oe_d;
        end
    end

    assign SO      = so_q;
    assign SO_OE   = so_oe_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_stb  = wr_stb_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed table, corner sequences and random frames.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int DW     = 8;
    localparam int AW     = 7;
    localparam int NR     = 8;
    localparam int DW16   = 16;
    localparam int T_HIGH = 3;
    localparam int T_LOW  = 6;
`ifdef SPI_BURST_EN
    localparam int BURST_STB = 2;
`else
    localparam int BURST_STB = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic sck = 1'b0, si = 1'b0, cs = 1'b0, cs16 = 1'b0;
    logic so, so_oe, wr_stb, busy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NR*DW-1:0] rd_regs;
    logic so16, so_oe16, wr_stb16, busy16;
    logic [AW-1:0] wr_addr16;
    logic [DW16-1:0] wr_data16;
    logic [NR*DW16-1:0] rd_regs16;

    spi_reg_slave #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) u_dut (
        .FX2_CLK(clk), .RST(rst), .SCK(sck), .SI(si), .CS(cs),
        .SO(so), .SO_OE(so_oe), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_stb(wr_stb), .rd_regs(rd_regs), .busy(busy)
    );

    spi_reg_slave #(.DATA_W(DW16), .ADDR_W(AW), .NREGS(NR)) u_dut16 (
        .FX2_CLK(clk), .RST(rst), .SCK(sck), .SI(si), .CS(cs16),
        .SO(so16), .SO_OE(so_oe16), .wr_addr(wr_addr16), .wr_data(wr_data16),
        .wr_stb(wr_stb16), .rd_regs(rd_regs16), .busy(busy16)
    );

    // ---------------- scoreboard and reference model ----------------
    int errors = 0;
    int checks = 0;
    int last_rise = 0;
    int stb_seen = 0;
    int stb16_cnt = 0;
    logic [14:0] exp_q[$];
    logic [14:0] mon_e;
    logic [DW-1:0] regs [NR];
    logic use16 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [6:0] a);
        return (int'(a) < NR) ? regs[a] : '0;
    endfunction

    task automatic pack_regs();
        for (int k = 0; k < NR; k++) rd_regs[k*DW +: DW] = regs[k];
    endtask

    always @(negedge clk) begin
        if (wr_stb16) stb16_cnt++;
        if (wr_stb) begin
            stb_seen++;
            chk("stb_latency", cyc - last_rise, 4);
            if (exp_q.size() == 0) begin
                chk("stb_unexpected", {17'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_word", {17'h0, wr_addr, wr_data}, {17'h0, mon_e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic spi_bit(input logic b, input logic drop_cs,
                           output logic so_s, output logic oe3, output logic oe4);
        si = b;
        @(negedge clk);
        so_s = use16 ? so16 : so;
        sck = 1'b1;
        last_rise = cyc + 1;
        if (drop_cs) begin
            cs = 1'b0;
            cs16 = 1'b0;
        end
        repeat (T_HIGH) @(negedge clk);
        sck = 1'b0;
        oe3 = 1'b0;
        oe4 = 1'b0;
        for (int j = 0; j < T_LOW; j++) begin
            @(negedge clk);
            if (j == 0) oe3 = use16 ? so_oe16 : so_oe;
            if (j == 1) oe4 = use16 ? so_oe16 : so_oe;
        end
    endtask

    task automatic xfer(input logic [31:0] w, input int n, input logic drop_last,
                        output logic [31:0] r, output logic oe3, output logic oe4);
        logic s;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(w[i], drop_last && (i == 0), s, oe3, oe4);
            r = {r[30:0], s};
        end
    endtask

    task automatic cs_on(input logic sel16);
        use16 = sel16;
        if (sel16) cs16 = 1'b1;
        else cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_off();
        repeat (4) @(negedge clk);
        cs = 1'b0;
        cs16 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        logic [31:0] r;
        logic o3, o4;
        cs_on(1'b0);
        xfer({24'h0, 1'b0, a}, 8, 1'b0, r, o3, o4);
        exp_q.push_back({a, d});
        xfer({24'h0, d}, 8, 1'b0, r, o3, o4);
        cs_off();
    endtask

    task automatic do_read(input logic [6:0] a, input logic sel16, input int n,
                           output logic [31:0] r, output logic a3, output logic a4,
                           output logic d3, output logic d4);
        cs_on(sel16);
        xfer({24'h0, 1'b1, a}, 8, 1'b0, r, a3, a4);
        xfer(32'h0, n, 1'b0, r, d3, d4);
        cs_off();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;
    localparam int NV = 8;
    vec_t tbl [NV];

    initial begin
        logic [31:0] r;
        logic a3, a4, d3, d4, o3, o4;
        int base;
        logic rw;
        logic [6:0] ra;
        logic [7:0] rdat;

        regs[0] = 8'h5A; regs[1] = 8'h81; regs[2] = 8'hC3; regs[3] = 8'h3C;
        regs[4] = 8'h0F; regs[5] = 8'hF0; regs[6] = 8'h99; regs[7] = 8'h66;
        pack_regs();
        rd_regs16 = '0;
        rd_regs16[0 +: 16]  = 16'h1234;
        rd_regs16[16 +: 16] = 16'hBEEF;

        tbl[0] = '{1'b0, 7'h05, 8'hA5, 8'h00};
        tbl[1] = '{1'b1, 7'h03, 8'h00, 8'h3C};
        tbl[2] = '{1'b1, 7'h7F, 8'h00, 8'h00};
        tbl[3] = '{1'b0, 7'h00, 8'hFF, 8'h00};
        tbl[4] = '{1'b1, 7'h07, 8'h00, 8'h66};
        tbl[5] = '{1'b1, 7'h00, 8'h00, 8'h5A};
        tbl[6] = '{1'b0, 7'h7F, 8'h01, 8'h00};
        tbl[7] = '{1'b1, 7'h08, 8'h00, 8'h00};

        // Reset values
        repeat (4) @(negedge clk);
        chk("rst_so", so, 0);
        chk("rst_so_oe", so_oe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rw) begin
                do_read(tbl[i].addr, 1'b0, DW, r, a3, a4, d3, d4);
                chk("tbl_rd_data", r, {24'h0, tbl[i].exp_rd});
                chk("tbl_oe_before", a3, 0);
                chk("tbl_oe_rise", a4, 1);
                chk("tbl_oe_last", d3, 1);
                chk("tbl_oe_after", d4, 0);
            end else begin
                base = stb_seen;
                do_write(tbl[i].addr, tbl[i].wdata);
                chk("tbl_wr_count", stb_seen - base, 1);
            end
            chk("tbl_busy_idle", busy, 0);
        end

        // Aborted write after 5 data bits, then a clean write
        base = stb_seen;
        cs_on(1'b0);
        xfer({24'h0, 8'h05}, 8, 1'b0, r, o3, o4);
        chk("busy_frame", busy, 1);
        xfer(32'h1F, 5, 1'b0, r, o3, o4);
        cs_off();
        chk("abort_no_stb", stb_seen - base, 0);
        do_write(7'h02, 8'h11);
        chk("after_abort_stb", stb_seen - base, 1);

        // CS drops together with the final SCK rise
        base = stb_seen;
        cs_on(1'b0);
        xfer({24'h0, 8'h06}, 8, 1'b0, r, o3, o4);
        exp_q.push_back({7'h06, 8'h6B});
        xfer(32'h6B, 8, 1'b1, r, o3, o4);
        cs_off();
        chk("cs_drop_last_stb", stb_seen - base, 1);

        // Two-word write at the top address
        base = stb_seen;
        cs_on(1'b0);
        xfer({24'h0, 8'h7F}, 8, 1'b0, r, o3, o4);
        exp_q.push_back({7'h7F, 8'h01});
        xfer(32'h01, 8, 1'b0, r, o3, o4);
`ifdef SPI_BURST_EN
        exp_q.push_back({7'h00, 8'h02});
`endif
        xfer(32'h02, 8, 1'b0, r, o3, o4);
        chk("busy_held", busy, 1);
        cs_off();
        chk("burst_stb_count", stb_seen - base, BURST_STB);

        // Read data is captured at address completion
        cs_on(1'b0);
        xfer({24'h0, 8'h82}, 8, 1'b0, r, o3, o4);
        rdat = regs[2];
        regs[2] = ~regs[2];
        pack_regs();
        xfer(32'h0, 8, 1'b0, r, o3, o4);
        cs_off();
        chk("rd_capture", r, {24'h0, rdat});

        // 16-bit instance
        do_read(7'h01, 1'b1, DW16, r, a3, a4, d3, d4);
        chk("rd16_data", r, 32'h0000_BEEF);
        chk("rd16_oe_rise", a4, 1);
        chk("rd16_oe_after", d4, 0);
        use16 = 1'b0;

        // Reset pulsed mid-read
        cs_on(1'b0);
        xfer({24'h0, 8'h83}, 8, 1'b0, r, o3, o4);
        xfer(32'h0, 3, 1'b0, r, o3, o4);
        rst = 1'b1;
        #1;
        chk("rst_mid_so_oe", so_oe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_so", so, 0);
        @(negedge clk);
        cs = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        do_read(7'h03, 1'b0, DW, r, a3, a4, d3, d4);
        chk("rd_after_rst", r, {24'h0, model_read(7'h03)});

        // Random frames against the model
        for (int n = 0; n < 40; n++) begin
            regs[$urandom_range(0, NR - 1)] = DW'($urandom);
            pack_regs();
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, NR - 1)) : 7'($urandom_range(0, 127));
            if (rw) begin
                do_read(ra, 1'b0, DW, r, a3, a4, d3, d4);
                chk("rnd_rd", r, {24'h0, model_read(ra)});
            end else begin
                base = stb_seen;
                do_write(ra, 8'($urandom));
                chk("rnd_wr_count", stb_seen - base, 1);
            end
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("dut16_no_write", stb16_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI register slave running entirely in the FX2_CLK domain. It receives an address byte, then either captures a write word or shifts out a readback word. It is the next-generation GPIO register port between the FX2 host and the FPGA register space. Unlike the earlier bit-clocked slave, SCK, SI and CS are oversampled and synchronised. Word width and register count are generic, aborted frames are rejected, and there is an optional address auto-increment burst mode.

## Interface
Parameters:
- DATA_W, 8 — data word width in bits (8..32).
- ADDR_W, 7 — address width in bits; the address byte is always 8 bits, and ADDR_W ≤ 7.
- NREGS, 8 — number of readback registers (1..2^ADDR_W).

Ports:
- Clocking and reset: one clock, FX2_CLK; reset RST is asynchronous and active-high.
- FX2_CLK  in  1  master clock.
- RST  in  1  asynchronous active-high reset.
- SCK  in  1  serial clock, asynchronous to FX2_CLK.
- SI  in  1  serial data in, MSB first.
- CS  in  1  chip select, active high.
- SO  out  1  serial data out, valid while SO_OE=1.
- SO_OE  out  1  output enable for the pad tristate; high only during the data phase of a read.
- wr_addr  out  ADDR_W  address of the last completed write.
- wr_data  out  DATA_W  data of the last completed write.
- wr_stb  out  1  one-cycle pulse per completed write word.
- rd_regs  in  NREGS*DATA_W  flattened readback registers; register k occupies bits [k*DATA_W +: DATA_W].
- busy  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Input conditioning: SCK, SI and CS each pass through a 2-flop synchroniser.
  - SCK rise and fall events are detected from the synchronised SCK versus its previous value.
  - SCK high and low times must each be ≥ 2 FX2_CLK periods.
- Frame format: address byte first, bit 7 = R/nW, bits [ADDR_W-1:0] = address, remaining bits ignored. The data word of DATA_W bits follows, MSB first.
- SI is shifted in on each synchronised SCK rise. SO changes on each synchronised SCK fall.
- States:
  - IDLE: wait for CS high; go to ADDR with the bit counter at 0.
  - ADDR: shift 8 bits. After bit 8:
    - A write goes to WDATA.
    - A read latches rd_regs[addr] into the shift register (0 if addr ≥ NREGS), sets SO_OE=1 with SO=MSB, and goes to RDATA.
  - WDATA: shift DATA_W bits. After the last bit, update wr_addr and wr_data, pulse wr_stb, then go to NEXT.
  - RDATA: shift out on falls and count rises. After DATA_W rises, go to NEXT.
  - NEXT: burst handling, see Configuration. Otherwise stay here, ignoring SCK, until CS drops.
- CS low in any state returns to IDLE on the next cycle and sets SO_OE=0.
  - A partially received write word is discarded and no wr_stb is issued.
- The bit counter is sized to $clog2(DATA_W+1) and saturates; it never wraps within a word.
- Read data is captured once, at address completion. Later changes to rd_regs do not affect the word being shifted.

## Timing
- Reset values: SO=0, SO_OE=0, wr_addr=0, wr_data=0, wr_stb=0, busy=0, state IDLE.
- wr_stb is asserted exactly 4 FX2_CLK cycles after the first FX2_CLK edge that samples the final SCK rise high. It lasts 1 cycle; wr_addr and wr_data are stable from that cycle until the next write.
- SO_OE rises 4 FX2_CLK cycles after the 8th address SCK rise. SO updates 4 cycles after each SCK fall.
  - The host samples SO on SCK rise. SCK low time must therefore be ≥ 5 FX2_CLK periods for read timing.
- CS falling together with the final SCK rise: the SCK event is processed first, so the word completes and wr_stb fires.
- RST asserted mid-frame: immediate return to reset values. The frame in progress is lost.

## Configuration
- SPI_BURST_EN defined:
  - In NEXT, if CS is still high, the address increments. Wrap is modulo 2^ADDR_W.
  - The block then re-enters WDATA or RDATA with the same R/nW and no new address byte.
  - A read reloads from rd_regs at the new address, 4 cycles after the last rise of the previous word.
- SPI_BURST_EN undefined: one word per CS assertion. Extra SCK edges are ignored until CS drops.

## Structure
- Package spi_reg_pkg holds:
  - the state enum (IDLE, ADDR, WDATA, RDATA, NEXT);
  - RW_BIT=7, ADDR_BYTE_W=8, SYNC_STAGES=2.
- Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall detector. It is instantiated for SCK, and its synchroniser path is reused for SI and CS.

## Test plan
- Write addr 0x05, data 0xA5 → single wr_stb, wr_addr=5, wr_data=0xA5; wr_stb exactly 4 cycles after the last synchronised SCK rise.
- rd_regs[3]=0x3C, read addr 0x03 → SO shifts 0,0,1,1,1,1,0,0; SO_OE high only during the data phase; read addr 0x7F with NREGS=8 → 0x00.
- CS dropped after 5 data bits of a write → no wr_stb; next full write 0x02/0x11 succeeds normally.
- Burst (SPI_BURST_EN) write addr 0x7F, data 0x01,0x02 → two strobes, wr_addr 0x7F then 0x00; without the macro → one strobe only.
- DATA_W=16, read addr 1 with rd_regs[1]=0xBEEF → 16 bits shifted out MSB-first.
- RST pulsed mid-read → SO_OE=0 and busy=0 immediately; next frame decodes correctly.
